// File: rtl/bitserial_mux_sel_scheduler.sv
// Zero-skipping select sequencer for the bit-serial PE operand mux.
// Emits one beat per set weight bit, MSB first, lane 0 before lane 1 at equal position.
module bitserial_mux_sel_scheduler #(
   parameter int DATA_WIDTH  = 8,
   parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_w0,
   input  logic [DATA_WIDTH-1:0]  in_w1,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [1:0]             out_sel,
   output logic [SHIFT_WIDTH-1:0] out_shift,
   output logic                   out_last,
   output logic                   busy
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   m0_reg, m0_next;
   logic [DATA_WIDTH-1:0]   m1_reg, m1_next;
   logic                    zjob_reg, zjob_next;

   logic [DATA_WIDTH-1:0]   any_bits;
   logic [SHIFT_WIDTH-1:0]  pos;
   logic [DATA_WIDTH-1:0]   pos_onehot;
   logic                    lane0_hit;
   logic [DATA_WIDTH-1:0]   clr0, clr1;
   logic [DATA_WIDTH-1:0]   rem_bits;
   logic                    issuing;

   assign any_bits = m0_reg | m1_reg;

   // Highest set index wins because later iterations overwrite earlier ones.
   always_comb begin
      pos = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (any_bits[i]) pos = SHIFT_WIDTH'(i);
      end
   end

   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_onehot
         assign pos_onehot[gi] = any_bits[gi] && (pos == SHIFT_WIDTH'(gi));
      end
   endgenerate

   assign lane0_hit = |(m0_reg & pos_onehot);
   assign clr0      = lane0_hit ? pos_onehot : '0;
   assign clr1      = lane0_hit ? '0 : pos_onehot;
   // Last beat when nothing remains in either lane after this beat's bit is cleared.
   assign rem_bits  = (m0_reg & ~clr0) | (m1_reg & ~clr1);

   assign issuing   = rst_n && (state_reg == ISSUE);
   assign in_ready  = rst_n && (state_reg == IDLE);
   assign out_valid = issuing;
   assign busy      = issuing;
   assign out_last  = issuing && (zjob_reg || (rem_bits == '0));

   always_comb begin
      out_sel   = 2'b10;
      out_shift = '0;
      if (issuing && !zjob_reg) begin
         out_sel   = lane0_hit ? 2'b00 : 2'b01;
         out_shift = pos;
      end
   end

   always_comb begin
      state_next = state_reg;
      m0_next    = m0_reg;
      m1_next    = m1_reg;
      zjob_next  = zjob_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               m0_next    = in_w0;
               m1_next    = in_w1;
               zjob_next  = (in_w0 == '0) && (in_w1 == '0);
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (out_ready) begin
               m0_next = m0_reg & ~clr0;
               m1_next = m1_reg & ~clr1;
               if (zjob_reg || (rem_bits == '0)) begin
                  state_next = IDLE;
                  zjob_next  = 1'b0;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         m0_reg    <= '0;
         m1_reg    <= '0;
         zjob_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         m0_reg    <= m0_next;
         m1_reg    <= m1_next;
         zjob_reg  <= zjob_next;
      end
   end

endmodule

// File: tb/tb_bitserial_mux_sel_scheduler.sv
// Bench for bitserial_mux_sel_scheduler: directed and random jobs checked against
// a beat list built straight from the weight words.
module tb_bitserial_mux_sel_scheduler;

   localparam int DW = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_w0, in_w1;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_sel;
   logic [SW-1:0] out_shift;
   logic          out_last;
   logic          busy;

   int compared   = 0;
   int mismatched = 0;

   typedef struct packed {
      logic [1:0]    sel;
      logic [SW-1:0] shift;
      logic          last;
   } beat_t;

   beat_t exp_q[$];

   bitserial_mux_sel_scheduler #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_w0(in_w0), .in_w1(in_w1),
      .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
      .out_shift(out_shift), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected beats: scan positions MSB down, lane 0 before lane 1, zero job gets one 2'b10 beat.
   task automatic build_expected(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
      beat_t b;
      exp_q.delete();
      for (int p = DW - 1; p >= 0; p--) begin
         if (w0[p]) begin b.sel = 2'b00; b.shift = SW'(p); b.last = 1'b0; exp_q.push_back(b); end
         if (w1[p]) begin b.sel = 2'b01; b.shift = SW'(p); b.last = 1'b0; exp_q.push_back(b); end
      end
      if (exp_q.size() == 0) begin
         b.sel = 2'b10; b.shift = '0; b.last = 1'b1; exp_q.push_back(b);
      end else begin
         b = exp_q[exp_q.size() - 1];
         b.last = 1'b1;
         exp_q[exp_q.size() - 1] = b;
      end
   endtask

   // Present a job and wait (bounded) for acceptance; leaves in_valid per keep_valid.
   task automatic accept(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input bit keep_valid, input logic [DW-1:0] kw0);
      int waited = 0;
      while (!in_ready && waited < 40) begin tick(); waited++; end
      check("in_ready_before_accept", in_ready, 1'b1);
      in_valid = 1'b1; in_w0 = w0; in_w1 = w1;
      tick();
      if (keep_valid) begin in_w0 = kw0; in_w1 = '0; end
      else begin in_valid = 1'b0; in_w0 = $urandom; in_w1 = $urandom; end
   endtask

   // Walk the expected beats; first_stall < 0 means random stalls up to max_stall.
   task automatic expect_beats(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input int first_stall, input int max_stall);
      int n;
      build_expected(w0, w1);
      for (int k = 0; k < exp_q.size(); k++) begin
         n = (k == 0 && first_stall >= 0) ? first_stall : int'($urandom_range(max_stall, 0));
         for (int s = 0; s <= n; s++) begin
            out_ready = (s == n);
            check($sformatf("valid[%0d.%0d]", k, s), out_valid, 1'b1);
            check($sformatf("busy[%0d.%0d]", k, s), busy, 1'b1);
            check($sformatf("in_ready_issue[%0d.%0d]", k, s), in_ready, 1'b0);
            check($sformatf("sel[%0d.%0d]", k, s), out_sel, exp_q[k].sel);
            check($sformatf("shift[%0d.%0d]", k, s), out_shift, exp_q[k].shift);
            check($sformatf("last[%0d.%0d]", k, s), out_last, exp_q[k].last);
            tick();
         end
      end
      out_ready = 1'b0;
      check("idle_in_ready", in_ready, 1'b1);
      check("idle_valid", out_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_sel", out_sel, 2'b10);
   endtask

   task automatic run_job(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input int first_stall, input int max_stall);
      $display("job w0=%02h w1=%02h", w0, w1);
      accept(w0, w1, 1'b0, '0);
      expect_beats(w0, w1, first_stall, max_stall);
   endtask

   initial begin
      logic [DW-1:0] rw0, rw1;
      rst_n = 1'b0; in_valid = 1'b0; in_w0 = '0; in_w1 = '0; out_ready = 1'b0;
      tick(); tick();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_sel", out_sel, 2'b10);
      check("rst_shift", out_shift, 3'd0);
      check("rst_last", out_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      tick();

      // Directed jobs from the plan.
      run_job(8'h05, 8'h04, 0, 0);
      run_job(8'h00, 8'h00, 0, 0);
      run_job(8'hFF, 8'hFF, 0, 0);
      run_job(8'h81, 8'h00, 3, 0);

      // in_valid held through a job: the held word is captured only after the last beat.
      $display("job w0=10 w1=01 with in_valid held (w0=02)");
      accept(8'h10, 8'h01, 1'b1, 8'h02);
      expect_beats(8'h10, 8'h01, 0, 0);
      tick();
      in_valid = 1'b0;
      expect_beats(8'h02, 8'h00, 0, 0);

      // Reset after the first beat of a job discards it.
      $display("job w0=f0 w1=00 reset after beat 1");
      accept(8'hF0, 8'h00, 1'b0, '0);
      check("rbeat1_sel", out_sel, 2'b00);
      check("rbeat1_shift", out_shift, 3'd7);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      check("midrst_in_ready", in_ready, 1'b0);
      check("midrst_valid", out_valid, 1'b0);
      rst_n = 1'b1;
      #1;
      check("postrst_valid", out_valid, 1'b0);
      check("postrst_busy", busy, 1'b0);
      check("postrst_in_ready", in_ready, 1'b1);
      run_job(8'h01, 8'h00, 0, 0);

      // Random jobs with random backpressure; sparse words and zero jobs mixed in.
      for (int j = 0; j < 40; j++) begin
         rw0 = DW'($urandom);
         rw1 = DW'($urandom);
         if ($urandom_range(3, 0) == 0) rw0 = '0;
         if ($urandom_range(3, 0) == 0) rw1 = '0;
         if ($urandom_range(2, 0) == 0) rw0 = rw0 & DW'($urandom);
         run_job(rw0, rw1, -1, 2);
         if ($urandom_range(1, 0) == 1) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
